mux_sel_sequencer: RTL and testbench



---
 rtl/mux_sel_sequencer.sv | 159 +++++++++++++++
 tb/tb_mux_sel_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: drives the 2-bit channel select (S0,S1) of a 4:1 mux.
// It walks the enabled channels A..D, dwells DWELL cycles on each, and runs
// either as a continuous scan or as a single sweep. Valid marks a stable
// select on an enabled channel, ChAdv marks each select change/re-arm and
// Done marks the end of a single sweep.
module mux_sel_sequencer #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       En,
  input  logic       Start,
  input  logic       Mode,
  input  logic [3:0] Mask,
  output logic       S0,
  output logic       S1,
  output logic       Valid,
  output logic       Busy,
  output logic       ChAdv,
  output logic       Done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [1:0]       ch;
  logic [1:0]       ch_nxt;
  logic             valid_nxt;
  logic             busy_nxt;
  logic             chadv_nxt;
  logic             done_nxt;

  logic             start_ok;
  logic             adv;
  logic [1:0]       ch_first;
  logic [1:0]       ch_adv;
  logic             wrap;

  // First enabled channel strictly after cur, searching upward with wrap
  // 3->0; cur itself is the last candidate. Returns cur if none is enabled.
  function automatic logic [1:0] next_ch(input logic [3:0] m, input logic [1:0] cur);
    logic [1:0] idx;
    logic       found;
    next_ch = cur;
    found   = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = cur + 2'(i);
      if (m[idx] && !found) begin
        next_ch = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // Starting the search "after channel 3" yields the lowest enabled channel.
  assign start_ok = Start && (Mask != 4'b0000);
  assign adv      = En && (cnt == CNT_LAST);
  assign ch_first = next_ch(Mask, 2'd3);
  assign ch_adv   = next_ch(Mask, ch);
  assign wrap     = (ch_adv <= ch);

  assign S0 = ch[1];
  assign S1 = ch[0];

  // State register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: Start is only honoured in IDLE; RUN leaves on abort or end of sweep
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_ok) state_nxt = RUN;
      RUN:  if (adv && ((Mask == 4'b0000) || (Mode && wrap))) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/datapath next values: counter, select and one-cycle flags
  always_comb begin
    cnt_nxt   = cnt;
    ch_nxt    = ch;
    valid_nxt = Valid;
    busy_nxt  = Busy;
    chadv_nxt = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        busy_nxt  = 1'b0;
        if (start_ok) begin
          cnt_nxt   = '0;
          ch_nxt    = ch_first;
          valid_nxt = 1'b1;
          busy_nxt  = 1'b1;
          chadv_nxt = 1'b1;
        end
      end
      RUN: begin
        if (adv) begin
          cnt_nxt = '0;
          if (Mask == 4'b0000) begin
            // abort: no Done, select holds
            valid_nxt = 1'b0;
            busy_nxt  = 1'b0;
          end else if (Mode && wrap) begin
            // single sweep finished: select holds on the last channel
            valid_nxt = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            ch_nxt    = ch_adv;
            chadv_nxt = 1'b1;
          end
        end else if (En) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        valid_nxt = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // Registered counter, select and flags
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt   <= '0;
      ch    <= 2'b00;
      Valid <= 1'b0;
      Busy  <= 1'b0;
      ChAdv <= 1'b0;
      Done  <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      ch    <= ch_nxt;
      Valid <= valid_nxt;
      Busy  <= busy_nxt;
      ChAdv <= chadv_nxt;
      Done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench for mux_sel_sequencer: two instances (DWELL=4 and DWELL=1) share the
// stimulus; a behavioural model tracks each one and is compared every cycle,
// with literal expectations at key points of the directed scenarios.
module tb_mux_sel_sequencer;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       En = 1'b1;
  logic       Start = 1'b0;
  logic       Mode = 1'b0;
  logic [3:0] Mask = 4'b0000;

  logic S0_a, S1_a, Valid_a, Busy_a, ChAdv_a, Done_a;
  logic S0_b, S1_b, Valid_b, Busy_b, ChAdv_b, Done_b;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  mux_sel_sequencer #(.DWELL(4), .CNT_W(8)) dut_a (
    .Clk(Clk), .Rst_n(Rst_n), .En(En), .Start(Start), .Mode(Mode), .Mask(Mask),
    .S0(S0_a), .S1(S1_a), .Valid(Valid_a), .Busy(Busy_a), .ChAdv(ChAdv_a), .Done(Done_a)
  );

  mux_sel_sequencer #(.DWELL(1), .CNT_W(8)) dut_b (
    .Clk(Clk), .Rst_n(Rst_n), .En(En), .Start(Start), .Mode(Mode), .Mask(Mask),
    .S0(S0_b), .S1(S1_b), .Valid(Valid_b), .Busy(Busy_b), .ChAdv(ChAdv_b), .Done(Done_b)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    bit run;
    int pos;
    int ch;
    bit valid;
    bit busy;
    bit adv;
    bit done;
  } mstate_t;

  mstate_t m[2];
  int      m_dwell[2] = '{4, 1};

  function automatic int first_from(bit [3:0] mask, int from);
    for (int k = 0; k < 4; k++) begin
      if (mask[(from + k) % 4]) return (from + k) % 4;
    end
    return from;
  endfunction

  function automatic mstate_t mreset();
    mstate_t r;
    r.run = 0; r.pos = 0; r.ch = 0;
    r.valid = 0; r.busy = 0; r.adv = 0; r.done = 0;
    return r;
  endfunction

  function automatic mstate_t mstep(mstate_t s, int dwell, bit en, bit start,
                                    bit mode, bit [3:0] mask);
    mstate_t r;
    int nx;
    r = s;
    r.adv = 0;
    r.done = 0;
    if (!s.run) begin
      r.valid = 0;
      r.busy = 0;
      if (start && mask != 0) begin
        r.run = 1; r.pos = 0; r.ch = first_from(mask, 0);
        r.valid = 1; r.busy = 1; r.adv = 1;
      end
    end else if (en) begin
      if (s.pos < dwell - 1) begin
        r.pos = s.pos + 1;
      end else begin
        r.pos = 0;
        if (mask == 0) begin
          r.run = 0; r.valid = 0; r.busy = 0;
        end else begin
          nx = first_from(mask, (s.ch + 1) % 4);
          if (mode && nx <= s.ch) begin
            r.run = 0; r.valid = 0; r.busy = 0; r.done = 1;
          end else begin
            r.ch = nx; r.adv = 1;
          end
        end
      end
    end
    return r;
  endfunction

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      m[0] <= mreset();
      m[1] <= mreset();
    end else begin
      m[0] <= mstep(m[0], m_dwell[0], En, Start, Mode, Mask);
      m[1] <= mstep(m[1], m_dwell[1], En, Start, Mode, Mask);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, got, exp);
    end
  endtask

  function automatic logic [5:0] mvec(mstate_t s);
    return {2'(s.ch), s.valid, s.busy, s.adv, s.done};
  endfunction

  // Cycle-by-cycle comparison of both instances against the model
  always @(negedge Clk) begin
    chk("model_a", {2'b00, S0_a, S1_a, Valid_a, Busy_a, ChAdv_a, Done_a}, {2'b00, mvec(m[0])});
    chk("model_b", {2'b00, S0_b, S1_b, Valid_b, Busy_b, ChAdv_b, Done_b}, {2'b00, mvec(m[1])});
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    tick(2);
    Rst_n = 1'b1;
  endtask

  // Pulse Start for one edge; returns at the first negedge after it was sampled
  task automatic pulse_start(input bit [3:0] mk, input bit md);
    Mask  = mk;
    Mode  = md;
    Start = 1'b1;
    tick(1);
    Start = 1'b0;
  endtask

  // Literal check of instance a: {S0,S1}, Valid, Busy, ChAdv, Done
  task automatic lit_a(input string name, input int ch, input bit v, input bit b,
                       input bit a, input bit d);
    chk({name, "_ch"}, {6'b0, S0_a, S1_a}, 8'(ch));
    chk({name, "_flags"}, {4'b0, Valid_a, Busy_a, ChAdv_a, Done_a}, {4'b0, v, b, a, d});
  endtask

  initial begin
    // reset state
    tick(1);
    lit_a("reset", 0, 0, 0, 0, 0);
    Rst_n = 1'b1;
    tick(1);

    // continuous scan over all channels, 4 cycles each
    pulse_start(4'b1111, 1'b0);
    for (int k = 0; k <= 4; k++) begin
      lit_a("scan_adv", k % 4, 1, 1, 1, 0);
      tick(1);
      lit_a("scan_hold", k % 4, 1, 1, 0, 0);
      tick(3);
    end
    do_reset();

    // single sweep over B and D
    pulse_start(4'b1010, 1'b1);
    lit_a("sweep_b", 1, 1, 1, 1, 0);
    tick(4);
    lit_a("sweep_d", 3, 1, 1, 1, 0);
    tick(4);
    lit_a("sweep_done", 3, 0, 0, 0, 1);
    tick(1);
    lit_a("sweep_after", 3, 0, 0, 0, 0);
    do_reset();

    // single enabled channel, continuous: re-arms every 4 cycles
    pulse_start(4'b0100, 1'b0);
    lit_a("single_c0", 2, 1, 1, 1, 0);
    tick(4);
    lit_a("single_c1", 2, 1, 1, 1, 0);
    tick(4);
    lit_a("single_c2", 2, 1, 1, 1, 0);
    do_reset();

    // single enabled channel, single sweep
    pulse_start(4'b0100, 1'b1);
    tick(4);
    lit_a("single_done", 2, 0, 0, 0, 1);
    do_reset();

    // En dropped for 3 cycles at cnt=2 on channel B
    pulse_start(4'b1111, 1'b0);
    tick(6);
    lit_a("freeze_pre", 1, 1, 1, 0, 0);
    En = 1'b0;
    tick(3);
    lit_a("freeze_held", 1, 1, 1, 0, 0);
    En = 1'b1;
    tick(1);
    lit_a("freeze_one", 1, 1, 1, 0, 0);
    tick(1);
    lit_a("freeze_adv", 2, 1, 1, 1, 0);
    do_reset();

    // Mask cleared mid-dwell: finish dwell then abort without Done
    pulse_start(4'b1111, 1'b0);
    tick(1);
    Mask = 4'b0000;
    tick(2);
    lit_a("abort_dwell", 0, 1, 1, 0, 0);
    tick(1);
    lit_a("abort_idle", 0, 0, 0, 0, 0);
    pulse_start(4'b0000, 1'b0);
    tick(1);
    lit_a("abort_nostart", 0, 0, 0, 0, 0);

    // asynchronous reset mid-dwell on channel D
    pulse_start(4'b1111, 1'b0);
    tick(13);
    lit_a("pre_rst", 3, 1, 1, 0, 0);
    #2;
    Rst_n = 1'b0;
    #1;
    lit_a("async_rst", 0, 0, 0, 0, 0);
    tick(1);
    Rst_n = 1'b1;
    tick(1);

    // DWELL=1 instance changes channel every cycle
    pulse_start(4'b1111, 1'b0);
    for (int k = 0; k <= 4; k++) begin
      chk("dwell1_ch", {6'b0, S0_b, S1_b}, 8'(k % 4));
      chk("dwell1_adv", {7'b0, ChAdv_b}, 8'd1);
      tick(1);
    end
    do_reset();
    tick(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
